// File: rtl/param_up_down_counter_if.sv
// Control/status bundle for param_up_down_counter.
// Latency: none, plain wires between controller and counter.
// Backpressure: none; the counter accepts a command every cycle.
interface param_up_down_counter_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_flags;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             at_zero;
  logic             ovf;
  logic             unf;
  logic             ovf_sticky;
  logic             unf_sticky;

  // Controller side: issues commands, observes count and flags.
  modport master (
    output en, up_down, load, load_val, clr_flags,
    input  count, at_max, at_zero, ovf, unf, ovf_sticky, unf_sticky
  );

  // Counter side.
  modport slave (
    input  en, up_down, load, load_val, clr_flags,
    output count, at_max, at_zero, ovf, unf, ovf_sticky, unf_sticky
  );
endinterface

// File: rtl/param_up_down_counter.sv
// Parametrised up/down counter with load, wrap/saturate, and ovf/unf pulse + sticky flags.
// Latency: count/ovf/unf update on the edge that samples the command; at_max/at_zero are combinational.
// Backpressure: none; a command is consumed every cycle (priority load > en > hold).
module param_up_down_counter #(
  parameter int WIDTH    = 3,
  parameter int MAX_VAL  = (1 << WIDTH) - 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  param_up_down_counter_if.slave    bus
);

  localparam logic [WIDTH-1:0] MAX = MAX_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             ovf_sticky_q, ovf_sticky_d;
  logic             unf_sticky_q, unf_sticky_d;

  // Next-state: load clamps to MAX and never raises an event; counting
  // wraps between 0 and MAX (not 2^WIDTH-1) or holds at the end in saturate mode.
  always_comb begin
    count_d      = count_q;
    ovf_d        = 1'b0;
    unf_d        = 1'b0;
    ovf_sticky_d = bus.clr_flags ? 1'b0 : ovf_sticky_q;
    unf_sticky_d = bus.clr_flags ? 1'b0 : unf_sticky_q;

    if (bus.load) begin
      count_d = (bus.load_val > MAX) ? MAX : bus.load_val;
    end else if (bus.en) begin
      if (bus.up_down) begin
        if (count_q == MAX) begin
          ovf_d   = 1'b1;
          count_d = SATURATE ? MAX : '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          unf_d   = 1'b1;
          count_d = SATURATE ? '0 : MAX;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end

    // An event on the same edge as clr_flags leaves the flag set.
    if (ovf_d) ovf_sticky_d = 1'b1;
    if (unf_d) unf_sticky_d = 1'b1;
  end

  // State register; reset discards everything immediately without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q      <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      ovf_sticky_q <= 1'b0;
      unf_sticky_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      ovf_sticky_q <= ovf_sticky_d;
      unf_sticky_q <= unf_sticky_d;
    end
  end

  assign bus.count      = count_q;
  assign bus.at_max     = (count_q == MAX);
  assign bus.at_zero    = (count_q == '0);
  assign bus.ovf        = ovf_q;
  assign bus.unf        = unf_q;
  assign bus.ovf_sticky = ovf_sticky_q;
  assign bus.unf_sticky = unf_sticky_q;

endmodule

// File: tb/tb_param_up_down_counter.sv
// Directed bench for param_up_down_counter: wrap (3b, max 5), saturate (3b, max 5), and 8b/255 wrap.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Each task checks its own scenario inline and bumps checks/errors.
module tb_param_up_down_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  param_up_down_counter_if #(.WIDTH(3)) bw ();
  param_up_down_counter_if #(.WIDTH(3)) bs ();
  param_up_down_counter_if #(.WIDTH(8)) b8 ();

  param_up_down_counter #(.WIDTH(3), .MAX_VAL(5), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .bus(bw));
  param_up_down_counter #(.WIDTH(3), .MAX_VAL(5), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .bus(bs));
  param_up_down_counter #(.WIDTH(8), .MAX_VAL(255), .SATURATE(1'b0)) u_w8 (
    .clk(clk), .rst(rst), .bus(b8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bw.count !== 3'd0 || bw.ovf !== 1'b0 || bw.unf !== 1'b0 ||
        bw.ovf_sticky !== 1'b0 || bw.unf_sticky !== 1'b0 || bw.at_zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: count=%0d ovf=%b unf=%b os=%b us=%b az=%b, want 0,0,0,0,0,1",
               bw.count, bw.ovf, bw.unf, bw.ovf_sticky, bw.unf_sticky, bw.at_zero);
    end
    checks++;
    if (bs.count !== 3'd0 || b8.count !== 8'd0) begin
      errors++;
      $display("FAIL reset_state_others: sat=%0d w8=%0d, want 0,0", bs.count, b8.count);
    end
    tick();
    #3 rst = 1'b1;
    tick();
    // Drive count to 4 with ovf_sticky set, then reset mid-cycle.
    bw.load = 1'b1; bw.load_val = 3'd5;
    tick();
    bw.load = 1'b0; bw.en = 1'b1; bw.up_down = 1'b1;
    repeat (5) tick();
    checks++;
    if (bw.count !== 3'd4 || bw.ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL reset_precount: count=%0d os=%b, want 4,1", bw.count, bw.ovf_sticky);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bw.count !== 3'd0 || bw.ovf_sticky !== 1'b0 || bw.ovf !== 1'b0 || bw.unf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: count=%0d os=%b ovf=%b us=%b, want 0,0,0,0",
               bw.count, bw.ovf_sticky, bw.ovf, bw.unf_sticky);
    end
    #2 rst = 1'b1;
    tick();
    checks++;
    if (bw.count !== 3'd1) begin
      errors++;
      $display("FAIL reset_release: count=%0d, want 1", bw.count);
    end
  endtask

  task automatic test_wrap_up();
    logic [2:0] exp_c [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    logic       exp_o [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bw.en = 1'b0; bw.load = 1'b1; bw.load_val = 3'd0; bw.clr_flags = 1'b1;
    tick();
    bw.load = 1'b0; bw.clr_flags = 1'b0; bw.en = 1'b1; bw.up_down = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (bw.count !== exp_c[i] || bw.ovf !== exp_o[i]) begin
        errors++;
        $display("FAIL wrap_up[%0d]: count=%0d ovf=%b, want %0d,%b", i, bw.count, bw.ovf, exp_c[i], exp_o[i]);
      end
      if (i == 4) begin
        checks++;
        if (bw.at_max !== 1'b1 || bw.ovf_sticky !== 1'b0) begin
          errors++;
          $display("FAIL wrap_up_at_max: at_max=%b os=%b, want 1,0", bw.at_max, bw.ovf_sticky);
        end
      end
    end
    checks++;
    if (bw.ovf_sticky !== 1'b1 || bw.unf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL wrap_up_sticky: os=%b us=%b, want 1,0", bw.ovf_sticky, bw.unf_sticky);
    end
  endtask

  task automatic test_wrap_down();
    logic [2:0] exp_c [3] = '{3'd0, 3'd5, 3'd4};
    logic       exp_u [3] = '{1'b0, 1'b1, 1'b0};
    bw.en = 1'b0; bw.load = 1'b1; bw.load_val = 3'd1; bw.clr_flags = 1'b1;
    tick();
    bw.load = 1'b0; bw.clr_flags = 1'b0; bw.en = 1'b1; bw.up_down = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bw.count !== exp_c[i] || bw.unf !== exp_u[i] || bw.ovf !== 1'b0) begin
        errors++;
        $display("FAIL wrap_down[%0d]: count=%0d unf=%b ovf=%b, want %0d,%b,0",
                 i, bw.count, bw.unf, bw.ovf, exp_c[i], exp_u[i]);
      end
    end
    checks++;
    if (bw.unf_sticky !== 1'b1 || bw.ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL wrap_down_sticky: us=%b os=%b, want 1,0", bw.unf_sticky, bw.ovf_sticky);
    end
  endtask

  task automatic test_saturate();
    logic [2:0] exp_c [3] = '{3'd5, 3'd5, 3'd5};
    logic       exp_o [3] = '{1'b0, 1'b1, 1'b1};
    bs.load = 1'b1; bs.load_val = 3'd4;
    tick();
    bs.load = 1'b0; bs.en = 1'b1; bs.up_down = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bs.count !== exp_c[i] || bs.ovf !== exp_o[i]) begin
        errors++;
        $display("FAIL sat_up[%0d]: count=%0d ovf=%b, want %0d,%b", i, bs.count, bs.ovf, exp_c[i], exp_o[i]);
      end
    end
    bs.en = 1'b0; bs.load = 1'b1; bs.load_val = 3'd0;
    tick();
    bs.load = 1'b0; bs.en = 1'b1; bs.up_down = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bs.count !== 3'd0 || bs.unf !== 1'b1 || bs.unf_sticky !== 1'b1) begin
        errors++;
        $display("FAIL sat_down[%0d]: count=%0d unf=%b us=%b, want 0,1,1", i, bs.count, bs.unf, bs.unf_sticky);
      end
    end
    bs.en = 1'b0;
  endtask

  task automatic test_load();
    bw.load = 1'b1; bw.en = 1'b1; bw.up_down = 1'b1; bw.load_val = 3'd7;
    tick();
    checks++;
    if (bw.count !== 3'd5 || bw.ovf !== 1'b0) begin
      errors++;
      $display("FAIL load_clamp: count=%0d ovf=%b, want 5,0", bw.count, bw.ovf);
    end
    // At MAX with en=1 up: load still wins, no ovf event.
    tick();
    checks++;
    if (bw.count !== 3'd5 || bw.ovf !== 1'b0) begin
      errors++;
      $display("FAIL load_over_en: count=%0d ovf=%b, want 5,0", bw.count, bw.ovf);
    end
    bw.en = 1'b0; bw.load_val = 3'd2;
    tick();
    checks++;
    if (bw.count !== 3'd2) begin
      errors++;
      $display("FAIL load_val2: count=%0d, want 2", bw.count);
    end
    bw.load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bw.count !== 3'd2 || bw.ovf !== 1'b0 || bw.unf !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: count=%0d ovf=%b unf=%b, want 2,0,0", i, bw.count, bw.ovf, bw.unf);
      end
    end
  endtask

  task automatic test_flags();
    bw.load = 1'b1; bw.load_val = 3'd5; bw.clr_flags = 1'b1;
    tick();
    checks++;
    if (bw.ovf_sticky !== 1'b0 || bw.unf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL flags_clear: os=%b us=%b, want 0,0", bw.ovf_sticky, bw.unf_sticky);
    end
    bw.load = 1'b0; bw.en = 1'b1; bw.up_down = 1'b1; bw.clr_flags = 1'b1;
    tick();
    checks++;
    if (bw.ovf_sticky !== 1'b1 || bw.ovf !== 1'b1 || bw.count !== 3'd0) begin
      errors++;
      $display("FAIL flags_set_wins: os=%b ovf=%b count=%0d, want 1,1,0", bw.ovf_sticky, bw.ovf, bw.count);
    end
    bw.en = 1'b0;
    tick();
    checks++;
    if (bw.ovf_sticky !== 1'b0 || bw.ovf !== 1'b0) begin
      errors++;
      $display("FAIL flags_clr_alone: os=%b ovf=%b, want 0,0", bw.ovf_sticky, bw.ovf);
    end
    bw.clr_flags = 1'b0;
  endtask

  task automatic test_width8();
    b8.load = 1'b1; b8.load_val = 8'd254;
    tick();
    b8.load = 1'b0; b8.en = 1'b1; b8.up_down = 1'b1;
    tick();
    checks++;
    if (b8.count !== 8'd255 || b8.at_max !== 1'b1 || b8.ovf !== 1'b0) begin
      errors++;
      $display("FAIL w8_to_max: count=%0d at_max=%b ovf=%b, want 255,1,0", b8.count, b8.at_max, b8.ovf);
    end
    tick();
    checks++;
    if (b8.count !== 8'd0 || b8.ovf !== 1'b1 || b8.ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL w8_wrap: count=%0d ovf=%b os=%b, want 0,1,1", b8.count, b8.ovf, b8.ovf_sticky);
    end
    b8.up_down = 1'b0;
    tick();
    checks++;
    if (b8.count !== 8'd255 || b8.unf !== 1'b1 || b8.ovf !== 1'b0) begin
      errors++;
      $display("FAIL w8_unwrap: count=%0d unf=%b ovf=%b, want 255,1,0", b8.count, b8.unf, b8.ovf);
    end
    b8.en = 1'b0;
  endtask

  initial begin
    bw.en = 1'b0; bw.up_down = 1'b0; bw.load = 1'b0; bw.load_val = '0; bw.clr_flags = 1'b0;
    bs.en = 1'b0; bs.up_down = 1'b0; bs.load = 1'b0; bs.load_val = '0; bs.clr_flags = 1'b0;
    b8.en = 1'b0; b8.up_down = 1'b0; b8.load = 1'b0; b8.load_val = '0; b8.clr_flags = 1'b0;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load();
    test_flags();
    test_width8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
